uart_tx_serializer: RTL and testbench

UART transmitter that accepts bytes from the message-sequencing FSMs on a `txdata`/`ldtxdata` load interface and drives them onto the serial `tx` line as 8N1 frames. It is double-buffered: a one-byte holding register sits in front of a shift register. `txempty` tells the upstream FSM when the next byte may be loaded, so a sequencer that waits on `txempty` between bytes sends contiguous frames. It sits directly between the request/command FSMs and the board UART TX pin.

---
 rtl/uart_tx_serializer.sv | 148 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// Double-buffered 8N1 UART transmitter: holding register in front of a shift register.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1, 11 bit times per frame).
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] txdata,
   input  logic       ldtxdata,
   output logic       txempty,
   output logic       txidle,
   output logic       tx
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bitidx;
   logic [7:0]    shreg;
   logic [7:0]    hold;
   logic          hfull;

   logic bit_end;
   logic frame_done;
   logic take;
   logic goes_idle;
   logic hfull_n;

   assign bit_end    = (cnt == CNT_LAST);
   assign frame_done = (state == IDLE) || ((state == STOP) && bit_end);
   assign take       = hfull && frame_done;
   assign goes_idle  = !hfull && frame_done;
   // A transfer always wins over a same-cycle load, since it needs hfull set.
   assign hfull_n    = take ? 1'b0 : (hfull | ldtxdata);

   always_ff @(posedge clk) begin
      if (reset) begin
         hold  <= 8'h00;
         hfull <= 1'b0;
      end else begin
         if (ldtxdata && !hfull)
            hold <= txdata;
         hfull <= hfull_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         txempty <= 1'b1;
         txidle  <= 1'b1;
      end else begin
         txempty <= !hfull_n;
         txidle  <= goes_idle && !hfull_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         bitidx <= 3'd0;
         shreg  <= 8'h00;
         tx     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               tx  <= 1'b1;
               if (take) begin
                  shreg <= hold;
                  state <= START;
                  tx    <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt    <= '0;
                  bitidx <= 3'd0;
                  state  <= DATA;
                  tx     <= shreg[0];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bitidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= ^shreg;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bitidx <= bitidx + 3'd1;
                     tx     <= shreg[bitidx + 3'd1];
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= STOP;
                  tx    <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  // Pending byte starts immediately so frames are contiguous.
                  if (take) begin
                     shreg <= hold;
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 4 clocks per bit; honours UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FL = FB * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] txdata;
   logic       ldtxdata;
   logic       txempty;
   logic       txidle;
   logic       tx;
   logic [7:0] rx;

   int checks   = 0;
   int failures = 0;

   uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .reset    (reset),
      .txdata   (txdata),
      .ldtxdata (ldtxdata),
      .txempty  (txempty),
      .txidle   (txidle),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected line level at cycle offset 'off' from the first start-bit cycle.
   function automatic logic exp_bit(input logic [7:0] b, input int off);
      int s;
      s = off / CPB;
      if (s == 0) return 1'b0;
      if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
      if (s == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   initial begin
      reset    = 1'b1;
      ldtxdata = 1'b0;
      txdata   = 8'h00;
      rx       = 8'h00;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_tx", tx, 1);
         chk("rst_txempty", txempty, 1);
         chk("rst_txidle", txidle, 1);
      end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("idle_tx", tx, 1);
         chk("idle_txempty", txempty, 1);
         chk("idle_txidle", txidle, 1);
      end

      // Single frame 0x64
      @(negedge clk);
      ldtxdata = 1'b1;
      txdata   = 8'h64;
      @(negedge clk);
      ldtxdata = 1'b0;
      txdata   = 8'h00;
      chk("one_txempty_n1", txempty, 0);
      chk("one_txidle_n1", txidle, 0);
      chk("one_tx_n1", tx, 1);
      for (int c = 2; c < FL + 2; c++) begin
         @(negedge clk);
         chk("one_tx", tx, exp_bit(8'h64, c - 2));
         if (c == 2) chk("one_txempty_n2", txempty, 1);
         if (c == FL + 1) chk("one_txidle_laststop", txidle, 0);
      end
      @(negedge clk);
      chk("one_txidle_end", txidle, 1);
      chk("one_tx_end", tx, 1);
      chk("one_txempty_end", txempty, 1);

      // Back-to-back 0x6F then 0x66, with an ignored 0xFF strobe while full
      @(negedge clk);
      ldtxdata = 1'b1;
      txdata   = 8'h6F;
      @(negedge clk);
      ldtxdata = 1'b0;
      chk("b2b_txempty_n1", txempty, 0);
      for (int c = 2; c < 2 * FL + 2; c++) begin
         int off;
         int fo;
         @(negedge clk);
         off = c - 2;
         fo  = (off < FL) ? off : off - FL;
         chk("b2b_tx", tx, exp_bit((off < FL) ? 8'h6F : 8'h66, fo));
         if ((fo % CPB) == CPB / 2 && (fo / CPB) >= 1 && (fo / CPB) <= 8)
            rx[(fo / CPB) - 1] = tx;
         if (off == FL - 1) chk("b2b_byte0", rx, 8'h6F);
         if (off == 2 * FL - 1) chk("b2b_byte1", rx, 8'h66);
         if (off == FL) chk("b2b_nogap_txidle", txidle, 0);
         if (c == 2) begin
            chk("b2b_txempty_n2", txempty, 1);
            ldtxdata = 1'b1;
            txdata   = 8'h66;
         end else if (c == 3) begin
            chk("b2b_txempty_full", txempty, 0);
            txdata = 8'hFF;
         end else if (c == 4) begin
            ldtxdata = 1'b0;
            txdata   = 8'h00;
         end
      end
      @(negedge clk);
      chk("b2b_txidle_end", txidle, 1);
      chk("b2b_txempty_end", txempty, 1);
      for (int i = 0; i < 2 * CPB; i++) begin
         @(negedge clk);
         chk("b2b_no_ff_frame", tx, 1);
      end

      // Reset during data bit 3 with a second byte pending
      @(negedge clk);
      ldtxdata = 1'b1;
      txdata   = 8'hA5;
      @(negedge clk);
      ldtxdata = 1'b0;
      for (int c = 2; c <= 2 + 4 * CPB; c++) begin
         @(negedge clk);
         chk("rmf_tx", tx, exp_bit(8'hA5, c - 2));
         if (c == 2) begin
            ldtxdata = 1'b1;
            txdata   = 8'h3C;
         end else if (c == 3) begin
            ldtxdata = 1'b0;
            chk("rmf_pending", txempty, 0);
         end
         if (c == 2 + 4 * CPB) reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      chk("rmf_tx_after", tx, 1);
      chk("rmf_txempty_after", txempty, 1);
      chk("rmf_txidle_after", txidle, 1);
      for (int i = 0; i < FL + 10; i++) begin
         @(negedge clk);
         chk("rmf_no_start", tx, 1);
         chk("rmf_stay_idle", txidle, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
